id_hazard_ctrl: RTL and testbench

- Pipeline interlock controller for the decode stage. It sits beside the ID decoder and consumes the decoded register fields and control bits, plus the EX-stage control bits.
- It generates stall, bubble and flush controls for the PC, IF/ID and ID/EX registers.
- It sequences the shared multi-cycle multiply/divide unit through an internal busy FSM, and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/id_hazard_ctrl.sv | 99 +++++++++
 tb/tb_id_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// Decode-stage interlock: load-use and mul/div hazard detection, branch flush,
// mul/div busy sequencing and a saturating stall-cycle counter.
module id_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_muldiv,
  input  logic             id_is_div,
  input  logic             id_reads_hilo,
  input  logic             ex_valid,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_wreg,
  input  logic             branch_taken,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MD_W = 6;
  localparam logic [MD_W-1:0] MUL_LOAD = MD_W'(MUL_CYCLES - 1);
  localparam logic [MD_W-1:0] DIV_LOAD = MD_W'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  md_state_e         state_q, state_d;
  logic [MD_W-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic busy_c, last_c, lu_c, md_c, issue_c, stall_c;

  // Hazard detection; $zero is never a real producer.
  always_comb begin
    busy_c  = (state_q == RUN);
    last_c  = busy_c && (md_cnt_q == '0);
    lu_c    = id_valid && ex_valid && ex_MemRead && (ex_wreg != 5'd0) &&
              ((id_use_rs && (id_rs == ex_wreg)) || (id_use_rt && (id_rt == ex_wreg)));
    md_c    = id_valid && busy_c && (id_is_muldiv || id_reads_hilo);
    issue_c = !busy_c && id_valid && id_is_muldiv && !branch_taken && !lu_c;
    stall_c = !branch_taken && (lu_c || md_c);
  end

  // Next-state for the mul/div sequencer and the stall counter.
  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE) begin
      if (issue_c) begin
        state_d  = RUN;
        md_cnt_d = id_is_div ? DIV_LOAD : MUL_LOAD;
      end
    end else begin
      if (md_cnt_q == '0) state_d = IDLE;
      else                md_cnt_d = md_cnt_q - MD_W'(1);
    end
    if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // All controls are held low while reset is asserted.
  always_comb begin
    stall_pc    = rst_n && stall_c;
    stall_ifid  = rst_n && stall_c;
    bubble_idex = rst_n && (branch_taken || lu_c || md_c);
    flush_ifid  = rst_n && branch_taken;
    md_start    = rst_n && issue_c;
    md_busy     = rst_n && busy_c;
    md_done     = rst_n && last_c;
    stall_cnt   = rst_n ? stall_cnt_q : '0;
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: table vectors plus multi-cycle
// mul/div, reset-abort and counter-saturation sequences.
module tb_id_hazard_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned MUL_C = 4;
  localparam int unsigned DIV_C = 32;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_is_muldiv;
    logic       id_is_div;
    logic       id_reads_hilo;
    logic       ex_valid;
    logic       ex_MemRead;
    logic [4:0] ex_wreg;
    logic       branch_taken;
  } in_t;

  typedef struct {
    logic [6:0]       ctrl;
    logic [CNT_W-1:0] cnt;
    string            name;
  } exp_t;

  typedef struct {
    in_t        vin;
    logic [6:0] ctrl;
    string      name;
  } vec_t;

  // ctrl bit order: stall_pc, stall_ifid, bubble_idex, flush_ifid, md_start, md_busy, md_done
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_STALL = 7'b1110000;
  localparam logic [6:0] C_FLUSH = 7'b0011000;
  localparam logic [6:0] C_START = 7'b0000100;
  localparam logic [6:0] C_BUSY  = 7'b0000010;
  localparam logic [6:0] C_DONE  = 7'b0000011;
  localparam logic [6:0] C_MDST  = 7'b1110010;
  localparam logic [6:0] C_MDSTD = 7'b1110011;

  logic clk = 1'b0;
  logic rst_n;
  in_t  drv;
  logic stall_pc, stall_ifid, bubble_idex, flush_ifid, md_start, md_busy, md_done;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (drv.id_valid),
    .id_rs        (drv.id_rs),
    .id_rt        (drv.id_rt),
    .id_use_rs    (drv.id_use_rs),
    .id_use_rt    (drv.id_use_rt),
    .id_is_muldiv (drv.id_is_muldiv),
    .id_is_div    (drv.id_is_div),
    .id_reads_hilo(drv.id_reads_hilo),
    .ex_valid     (drv.ex_valid),
    .ex_MemRead   (drv.ex_MemRead),
    .ex_wreg      (drv.ex_wreg),
    .branch_taken (drv.branch_taken),
    .stall_pc     (stall_pc),
    .stall_ifid   (stall_ifid),
    .bubble_idex  (bubble_idex),
    .flush_ifid   (flush_ifid),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .stall_cnt    (stall_cnt)
  );

  exp_t             sb[$];
  vec_t             tbl[$];
  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  function automatic in_t lu_v(input logic [4:0] r);
    in_t v = '0;
    v.ex_valid = 1'b1; v.ex_MemRead = 1'b1; v.ex_wreg = r;
    v.id_valid = 1'b1; v.id_use_rt = 1'b1; v.id_rt = r;
    return v;
  endfunction

  function automatic in_t md_v(input logic div);
    in_t v = '0;
    v.id_valid = 1'b1; v.id_is_muldiv = 1'b1; v.id_is_div = div;
    return v;
  endfunction

  function automatic in_t hilo_v();
    in_t v = '0;
    v.id_valid = 1'b1; v.id_reads_hilo = 1'b1;
    return v;
  endfunction

  // Drive one cycle (called at posedge+1), check at the following negedge.
  task automatic step(input in_t v, input logic [6:0] ctrl, input string nm);
    exp_t       e;
    logic [6:0] got;
    drv    = v;
    e.ctrl = ctrl;
    e.cnt  = rst_n ? exp_cnt : '0;
    e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    e   = sb.pop_front();
    got = {stall_pc, stall_ifid, bubble_idex, flush_ifid, md_start, md_busy, md_done};
    n_vec++;
    if (got !== e.ctrl) begin
      n_err++;
      $display("FAIL %s ctrl: got %b expected %b (t=%0t)", e.name, got, e.ctrl, $time);
    end
    n_vec++;
    if (stall_cnt !== e.cnt) begin
      n_err++;
      $display("FAIL %s stall_cnt: got %0d expected %0d (t=%0t)", e.name, stall_cnt, e.cnt, $time);
    end
    if (!rst_n) exp_cnt = '0;
    else if (ctrl[6] && exp_cnt != '1) exp_cnt = exp_cnt + CNT_W'(1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step('0, C_NONE, "reset");
    rst_n = 1'b1;
  endtask

  initial begin
    in_t v;
    rst_n = 1'b0;
    drv   = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single-cycle hazard table, FSM idle throughout.
    tbl.push_back('{'0, C_NONE, "idle"});
    tbl.push_back('{lu_v(5'd8), C_STALL, "lu_rt"});
    v = lu_v(5'd5); v.id_use_rt = 1'b0; v.id_rt = 5'd0; v.id_use_rs = 1'b1; v.id_rs = 5'd5;
    tbl.push_back('{v, C_STALL, "lu_rs"});
    tbl.push_back('{lu_v(5'd0), C_NONE, "zero_reg"});
    v = lu_v(5'd8); v.id_rt = 5'd9;
    tbl.push_back('{v, C_NONE, "reg_mismatch"});
    v = lu_v(5'd8); v.id_use_rt = 1'b0;
    tbl.push_back('{v, C_NONE, "no_use"});
    v = lu_v(5'd8); v.ex_MemRead = 1'b0;
    tbl.push_back('{v, C_NONE, "not_load"});
    v = lu_v(5'd8); v.id_valid = 1'b0;
    tbl.push_back('{v, C_NONE, "id_invalid"});
    v = lu_v(5'd8); v.ex_valid = 1'b0;
    tbl.push_back('{v, C_NONE, "ex_invalid"});
    v = '0; v.branch_taken = 1'b1;
    tbl.push_back('{v, C_FLUSH, "branch_only"});
    v = lu_v(5'd8); v.id_is_muldiv = 1'b1; v.branch_taken = 1'b1;
    tbl.push_back('{v, C_FLUSH, "branch_lu_mult"});
    v = lu_v(5'd8); v.id_is_muldiv = 1'b1;
    tbl.push_back('{v, C_STALL, "lu_mult"});
    tbl.push_back('{hilo_v(), C_NONE, "hilo_idle"});
    v = lu_v(5'd8); v.id_use_rs = 1'b1; v.id_rs = 5'd8;
    tbl.push_back('{v, C_STALL, "lu_both"});
    for (int i = 0; i < tbl.size(); i++) step(tbl[i].vin, tbl[i].ctrl, tbl[i].name);

    // Multiply, then a second MULT held (with a coincident load-use) until idle.
    do_reset();
    step(md_v(1'b0), C_START, "mul_start");
    step('0, C_BUSY, "mul_run1");
    step('0, C_BUSY, "mul_run2");
    v = lu_v(5'd7); v.id_is_muldiv = 1'b1;
    step(v, C_MDST, "mul2_stall_lu");
    step(v, C_MDSTD, "mul2_stall_done");
    step(md_v(1'b0), C_START, "mul2_issue");
    for (int k = 1; k <= int'(MUL_C); k++)
      step('0, (k == int'(MUL_C)) ? C_DONE : C_BUSY, "mul2_run");
    step('0, C_NONE, "mul2_idle");

    // Divide with MFLO arriving mid-run.
    do_reset();
    step(md_v(1'b1), C_START, "div_start");
    for (int k = 1; k <= 9; k++) step('0, C_BUSY, "div_run");
    for (int k = 10; k <= int'(DIV_C); k++)
      step(hilo_v(), (k == int'(DIV_C)) ? C_MDSTD : C_MDST, "mflo_stall");
    step(hilo_v(), C_NONE, "mflo_proceed");

    // Reset during RUN with md_cnt at 15 aborts the divide.
    do_reset();
    step(md_v(1'b1), C_START, "abort_start");
    for (int k = 1; k <= 16; k++) step('0, C_BUSY, "abort_run");
    rst_n = 1'b0;
    v = lu_v(5'd3); v.id_reads_hilo = 1'b1; v.branch_taken = 1'b1;
    step(v, C_NONE, "abort_in_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) step('0, C_NONE, "abort_no_done");

    // Counter saturation.
    do_reset();
    for (int k = 0; k < 20; k++) step(lu_v(5'd8), C_STALL, "sat_stall");
    step('0, C_NONE, "sat_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
